// File: rtl/alu_cmd_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer_if
// Groups the command and result handshakes of alu_cmd_issuer.
//   cmd_valid/cmd_ready : command handshake, payload cmd_op/cmd_a/cmd_b
//   res_valid/res_ready : result handshake, payload res_data/res_cout/res_op
// Modports:
//   slave  : the issuer (accepts commands, produces results)
//   master : the environment (produces commands, consumes results)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface alu_cmd_issuer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic       res_cout;
   logic [1:0] res_op;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data, res_cout, res_op
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data, res_cout, res_op
   );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Command front-end and result stage wrapped around a combinational 4-bit
// ALU (op 00 add, 01 sub, 10 compare, 11 AND). Commands are buffered in a
// DEPTH-entry FIFO, the head entry drives the ALU, and the ALU output is
// captured into a single-entry result register with its own handshake.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   bus (slave)      : command and result handshakes
//   alu_a/alu_b/alu_s: operands and op selector driven to the ALU
//   alu_out/alu_cout : ALU result and carry
//   count            : FIFO occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_cmd_issuer #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_cmd_issuer_if.slave    bus,
   output logic [3:0]         alu_a,
   output logic [3:0]         alu_b,
   output logic [1:0]         alu_s,
   input  logic [3:0]         alu_out,
   input  logic               alu_cout,
   output logic [PTR_W:0]     count
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Entry layout: {op[1:0], a[3:0], b[3:0]}
   logic [9:0]       mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q,  count_d;
   logic             res_valid_q, res_valid_d;
   logic [3:0]       res_data_q,  res_data_d;
   logic             res_cout_q,  res_cout_d;
   logic [1:0]       res_op_q,    res_op_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             issue;
   logic [9:0]       head_word;

   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);
      push       = bus.cmd_valid & ~fifo_full;
      // The slot may be refilled while its current result is being taken.
      issue      = ~fifo_empty & (~res_valid_q | bus.res_ready);
      head_word  = mem_q[rd_ptr_q];

      // An empty FIFO drives a quiet AND of zeros.
      if (fifo_empty) begin
         alu_a = 4'd0;
         alu_b = 4'd0;
         alu_s = 2'b11;
      end else begin
         alu_s = head_word[9:8];
         alu_a = head_word[7:4];
         alu_b = head_word[3:0];
      end
   end

   always_comb begin
      wr_ptr_d = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = issue ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      if (push && !issue) begin
         count_d = count_q + 1'b1;
      end else if (issue && !push) begin
         count_d = count_q - 1'b1;
      end

      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_cout_d  = res_cout_q;
      res_op_d    = res_op_q;
      if (issue) begin
         res_valid_d = 1'b1;
         res_data_d  = alu_out;
         // Carry is only meaningful for add/sub.
         res_cout_d  = alu_s[1] ? 1'b0 : alu_cout;
         res_op_d    = alu_s;
      end else if (res_valid_q && bus.res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= 4'd0;
         res_cout_q  <= 1'b0;
         res_op_q    <= 2'b00;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_cout_q  <= res_cout_d;
         res_op_q    <= res_op_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
      end
   end

   assign bus.cmd_ready = ~fifo_full;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_cout  = res_cout_q;
   assign bus.res_op    = res_op_q;
   assign count         = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] alu_a, alu_b, alu_out;
   logic [1:0] alu_s;
   logic       alu_cout;
   logic [2:0] count;

   always #5 clk = ~clk;

   alu_cmd_issuer_if bus();

   alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_s    (alu_s),
      .alu_out  (alu_out),
      .alu_cout (alu_cout),
      .count    (count)
   );

   // Gate-style ALU stand-in. Carry on compare/AND is driven high on purpose
   // so that the issuer's masking of res_cout is visible.
   logic [4:0] alu_sum;
   always_comb begin
      alu_sum  = 5'd0;
      alu_out  = 4'd0;
      alu_cout = 1'b1;
      case (alu_s)
         2'b00: begin alu_sum = {1'b0, alu_a} + {1'b0, alu_b};        alu_out = alu_sum[3:0]; alu_cout = alu_sum[4]; end
         2'b01: begin alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1; alu_out = alu_sum[3:0]; alu_cout = alu_sum[4]; end
         2'b10: alu_out = {1'b0, alu_a > alu_b, alu_a < alu_b, alu_a == alu_b};
         default: alu_out = alu_a & alu_b;
      endcase
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct { logic [1:0] op; logic [3:0] a; logic [3:0] b; } cmd_t;
   cmd_t       mq[$];
   logic       m_rv;
   logic [3:0] m_data;
   logic       m_cout;
   logic [1:0] m_op;

   function automatic void ref_result(input cmd_t c, output logic [3:0] d, output logic co);
      int ia, ib;
      ia = c.a; ib = c.b;
      case (c.op)
         2'b00: begin d = 4'((ia + ib) % 16); co = (ia + ib) > 15; end
         2'b01: begin d = 4'((ia - ib + 16) % 16); co = (ia >= ib); end
         2'b10: begin d = 4'((ia > ib) * 4 + (ia < ib) * 2 + (ia == ib)); co = 1'b0; end
         default: begin d = c.a & c.b; co = 1'b0; end
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rv = 1'b0; m_data = 4'd0; m_cout = 1'b0; m_op = 2'b00;
   endtask

   task automatic model_update();
      bit   iss, psh;
      cmd_t c;
      iss = (mq.size() != 0) && (!m_rv || bus.res_ready);
      psh = bus.cmd_valid && (mq.size() < DEPTH);
      if (iss) begin
         c = mq.pop_front();
         ref_result(c, m_data, m_cout);
         m_op = c.op;
         m_rv = 1'b1;
      end else if (m_rv && bus.res_ready) begin
         m_rv = 1'b0;
      end
      if (psh) begin
         c.op = bus.cmd_op; c.a = bus.cmd_a; c.b = bus.cmd_b;
         mq.push_back(c);
      end
   endtask

   task automatic check_model();
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(mq.size() < DEPTH));
      chk("count",     32'(count),         32'(mq.size()));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_data",  32'(bus.res_data),  32'(m_data));
      chk("res_cout",  32'(bus.res_cout),  32'(m_cout));
      chk("res_op",    32'(bus.res_op),    32'(m_op));
      if (mq.size() != 0) begin
         chk("alu_abs", {20'd0, alu_s, 2'b0, alu_a, alu_b}, {20'd0, mq[0].op, 2'b0, mq[0].a, mq[0].b});
      end else begin
         chk("alu_quiet", {20'd0, alu_s, 2'b0, alu_a, alu_b}, {20'd0, 2'b11, 2'b0, 4'd0, 4'd0});
      end
   endtask

   task automatic set_in(input logic v, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic r);
      bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.res_ready = r;
   endtask

   task automatic tick();
      model_update();
      @(posedge clk);
      #1;
      check_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic v; logic [1:0] op; logic [3:0] a; logic [3:0] b; logic r;
      logic rv; logic [3:0] d; logic co; logic [1:0] rop; logic [2:0] cnt; logic crdy;
      logic [3:0] xa; logic [3:0] xb; logic [1:0] xs;
   } vec_t;
   vec_t vecs[6];

   int         accepted;
   logic [3:0] held_data;

   initial begin
      //            v  op     a     b    r | rv d     co rop    cnt crdy xa    xb    xs
      vecs[0] = '{1, 2'b00, 4'h5, 4'h3, 1,  0, 4'h0, 0, 2'b00, 1, 1, 4'h5, 4'h3, 2'b00};
      vecs[1] = '{1, 2'b01, 4'h9, 4'h3, 1,  1, 4'h8, 0, 2'b00, 1, 1, 4'h9, 4'h3, 2'b01};
      vecs[2] = '{1, 2'b10, 4'h5, 4'h9, 1,  1, 4'h6, 1, 2'b01, 1, 1, 4'h5, 4'h9, 2'b10};
      vecs[3] = '{1, 2'b11, 4'hC, 4'hA, 1,  1, 4'h2, 0, 2'b10, 1, 1, 4'hC, 4'hA, 2'b11};
      vecs[4] = '{0, 2'b00, 4'h0, 4'h0, 1,  1, 4'h8, 0, 2'b11, 0, 1, 4'h0, 4'h0, 2'b11};
      vecs[5] = '{0, 2'b00, 4'h0, 4'h0, 1,  0, 4'h8, 0, 2'b11, 0, 1, 4'h0, 4'h0, 2'b11};

      set_in(0, 2'b00, 4'h0, 4'h0, 1);
      model_reset();
      #12;
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_res_bits",  {27'd0, bus.res_op, bus.res_cout, 2'b0} | 32'(bus.res_data), 0);
      chk("rst_count",     32'(count), 0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: first push, back-to-back ops, drain and hold.
      for (int i = 0; i < 6; i++) begin
         set_in(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
         tick();
         chk($sformatf("vec%0d_res", i),
             {24'd0, bus.res_valid, bus.res_cout, bus.res_op, bus.res_data},
             {24'd0, vecs[i].rv, vecs[i].co, vecs[i].rop, vecs[i].d});
         chk($sformatf("vec%0d_fifo", i), {28'd0, bus.cmd_ready, count},
             {28'd0, vecs[i].crdy, vecs[i].cnt});
         chk($sformatf("vec%0d_alu", i), {22'd0, alu_s, alu_a, alu_b},
             {22'd0, vecs[i].xs, vecs[i].xa, vecs[i].xb});
      end

      // Back-pressure: exactly DEPTH+1 commands fit, result held stable.
      accepted = 0;
      held_data = 4'd0;
      for (int i = 0; i < 9; i++) begin
         set_in(1, 2'($urandom), 4'($urandom), 4'($urandom), 0);
         if (bus.cmd_ready) accepted++;
         tick();
         if (i == 1) held_data = bus.res_data;
         if (i > 1) chk("bp_res_stable", 32'(bus.res_data), 32'(held_data));
      end
      chk("bp_accepted", accepted, DEPTH + 1);
      chk("bp_full", {28'd0, bus.cmd_ready, count}, {28'd0, 1'b0, 3'd4});
      for (int i = 0; i < 6; i++) begin
         set_in(0, 2'b00, 4'h0, 4'h0, 1);
         tick();
      end
      chk("bp_drained", {28'd0, bus.res_valid, count}, 0);

      // Reach count=2, then push and pop together for 6 cycles (wraps pointers).
      for (int i = 0; i < 3; i++) begin
         set_in(1, 2'($urandom), 4'($urandom), 4'($urandom), 0);
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         set_in(1, 2'($urandom), 4'($urandom), 4'($urandom), 1);
         tick();
         chk("steady_count", 32'(count), 2);
      end
      for (int i = 0; i < 4; i++) begin
         set_in(0, 2'b00, 4'h0, 4'h0, 1);
         tick();
      end

      // Asynchronous reset mid-cycle with count=3 and a held result.
      for (int i = 0; i < 4; i++) begin
         set_in(1, 2'($urandom), 4'($urandom), 4'($urandom), 0);
         tick();
      end
      chk("pre_rst_state", {28'd0, bus.res_valid, count}, {28'd0, 1'b1, 3'd3});
      set_in(0, 2'b00, 4'h0, 4'h0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_res", {24'd0, bus.res_valid, bus.res_cout, bus.res_op, bus.res_data}, 0);
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_alu", {22'd0, alu_s, alu_a, alu_b}, {22'd0, 2'b11, 8'd0});
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1, 2'b01, 4'h2, 4'h7, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(0, 2'b00, 4'h0, 4'h0, 1);
         tick();
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
                (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
